div_ctrl: RTL and testbench



---
 rtl/div_ctrl_pkg.sv | 29 ++
 rtl/div_sign_fix.sv | 17 +
 rtl/div_ctrl.sv | 172 +++++++++++++++++
 tb/tb_div_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared definitions for the divide issue controller.
// Holds the RV32M divide func3 codes, the controller state encoding and
// small decode helpers used by div_ctrl.
package div_ctrl_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [2:0] INST_DIV  = 3'b100;
  localparam logic [2:0] INST_DIVU = 3'b101;
  localparam logic [2:0] INST_REM  = 3'b110;
  localparam logic [2:0] INST_REMU = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } div_state_t;

  // DIV/REM are signed (func3[0]==0); REM/REMU select the remainder (func3[1]).
  function automatic logic f3_signed(input logic [2:0] f3);
    return ~f3[0];
  endfunction

  function automatic logic f3_rem(input logic [2:0] f3);
    return f3[1];
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// div_sign_fix: conditional two's-complement negate.
// Used both to take operand magnitudes (neg = signed & msb) and to apply
// the final sign to the unsigned divider results.
//   val : input value
//   neg : 1 -> res = -val, 0 -> res = val
//   res : result
module div_sign_fix #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] val,
  input  logic            neg,
  output logic [XLEN-1:0] res
);

  assign res = neg ? -val : val;

endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: issue/sequencing controller between EX and the multi-cycle
// unsigned divider. One RV32M divide/remainder op in flight at a time.
// Special cases (x/0, signed overflow) and repeat operands (reuse entry)
// are answered without starting the divider.
// Ports:
//   clk, rst (sync, active low)
//   req_*  : op request from EX (valid/ready), flush cancels in-flight op
//   stall  : hold the pipeline
//   dv_*   : divider start/abort, operand magnitudes, done + raw results
//   wb_*   : result to writeback (valid/ready)
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int REG_ADDR_W = 5,
  parameter bit REUSE_EN   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [XLEN-1:0]       req_op1,
  input  logic [XLEN-1:0]       req_op2,
  input  logic [2:0]            req_func3,
  input  logic [REG_ADDR_W-1:0] req_rd,
  input  logic                  flush,
  output logic                  stall,
  output logic                  dv_start,
  output logic [XLEN-1:0]       dv_dividend,
  output logic [XLEN-1:0]       dv_divisor,
  output logic                  dv_abort,
  input  logic                  dv_done,
  input  logic [XLEN-1:0]       dv_quotient,
  input  logic [XLEN-1:0]       dv_remainder,
  output logic                  wb_valid,
  input  logic                  wb_ready,
  output logic [XLEN-1:0]       wb_data,
  output logic [REG_ADDR_W-1:0] wb_rd
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  div_state_t state, state_nxt;

  // in-flight op
  logic [XLEN-1:0] op1_q, op2_q;
  logic            sgn_q, rem_q, qneg_q, rneg_q;

  // last divider result, keyed by operands and signedness
  logic            reuse_vld, reuse_sgn;
  logic [XLEN-1:0] reuse_op1, reuse_op2, reuse_quo, reuse_rem;

  logic            req_sgn, req_rem, accept, done_ok;
  logic            div_zero, ovfl, reuse_hit, short_path;
  logic [XLEN-1:0] short_res;

  assign req_sgn  = f3_signed(req_func3);
  assign req_rem  = f3_rem(req_func3);
  assign div_zero = (req_op2 == '0);
  assign ovfl     = req_sgn && (req_op1 == MIN_NEG) && (req_op2 == '1);
  assign reuse_hit = REUSE_EN && reuse_vld && (req_op1 == reuse_op1) &&
                     (req_op2 == reuse_op2) && (req_sgn == reuse_sgn);
  assign short_path = div_zero || ovfl || reuse_hit;

  always_comb begin
    short_res = req_rem ? reuse_rem : reuse_quo;
    if (div_zero)  short_res = req_rem ? req_op1 : '1;
    else if (ovfl) short_res = req_rem ? '0 : MIN_NEG;
  end

  // [0] dividend magnitude, [1] divisor magnitude,
  // [2] signed quotient,    [3] signed remainder
  logic [3:0][XLEN-1:0] fx_in, fx_out;
  logic [3:0]           fx_neg;

  assign fx_in  = {dv_remainder, dv_quotient, req_op2, req_op1};
  assign fx_neg = {rneg_q, qneg_q,
                   req_sgn & req_op2[XLEN-1], req_sgn & req_op1[XLEN-1]};

  for (genvar i = 0; i < 4; i++) begin : g_fix
    div_sign_fix #(.XLEN(XLEN)) u_fix (
      .val (fx_in[i]),
      .neg (fx_neg[i]),
      .res (fx_out[i])
    );
  end

  assign accept  = req_valid && req_ready;
  // a done in the flush cycle is dropped and never reaches the reuse entry
  assign done_ok = (state == ST_WAIT) && dv_done && !flush;

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    dv_start  = 1'b0;
    dv_abort  = 1'b0;
    wb_valid  = 1'b0;
    stall     = (req_valid && state != ST_IDLE) ||
                state == ST_ISSUE || state == ST_WAIT;
    case (state)
      ST_IDLE: begin
        req_ready = !flush;
        if (req_valid) state_nxt = short_path ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        dv_start  = !flush;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: if (dv_done) state_nxt = ST_RESP;
      ST_RESP: begin
        wb_valid = 1'b1;
        if (wb_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) begin
      state_nxt = ST_IDLE;
      dv_abort  = (state == ST_ISSUE) || (state == ST_WAIT);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= ST_IDLE;
      op1_q       <= '0;
      op2_q       <= '0;
      sgn_q       <= 1'b0;
      rem_q       <= 1'b0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      dv_dividend <= '0;
      dv_divisor  <= '0;
      wb_data     <= '0;
      wb_rd       <= '0;
      reuse_vld   <= 1'b0;
      reuse_sgn   <= 1'b0;
      reuse_op1   <= '0;
      reuse_op2   <= '0;
      reuse_quo   <= '0;
      reuse_rem   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op1_q <= req_op1;
        op2_q <= req_op2;
        sgn_q <= req_sgn;
        rem_q <= req_rem;
        wb_rd <= req_rd;
        if (short_path) begin
          wb_data <= short_res;
        end else begin
          dv_dividend <= fx_out[0];
          dv_divisor  <= fx_out[1];
        end
      end
      if (state == ST_ISSUE) begin
        qneg_q <= sgn_q & (op1_q[XLEN-1] ^ op2_q[XLEN-1]);
        rneg_q <= sgn_q & op1_q[XLEN-1];
      end
      if (done_ok) begin
        reuse_vld <= 1'b1;
        reuse_sgn <= sgn_q;
        reuse_op1 <= op1_q;
        reuse_op2 <= op2_q;
        reuse_quo <= fx_out[2];
        reuse_rem <= fx_out[3];
        wb_data   <= rem_q ? fx_out[3] : fx_out[2];
      end
    end
  end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed test-plan sequences followed by random traffic,
// all checked each cycle against a transaction-level model of the RV32M
// divide rules, with a behavioural divider answering dv_start.
module tb_div_ctrl;
  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int P_IDLE = 0, P_START = 1, P_WAIT = 2, P_RESP = 3;

  logic            clk = 1'b0, rst = 1'b0;
  logic            req_valid = 1'b0, flush = 1'b0, dv_done = 1'b0, wb_ready = 1'b0;
  logic [XLEN-1:0] req_op1 = '0, req_op2 = '0, dv_quotient = '0, dv_remainder = '0;
  logic [2:0]      req_func3 = 3'b100;
  logic [RW-1:0]   req_rd = '0;
  logic            req_ready, stall, dv_start, dv_abort, wb_valid;
  logic [XLEN-1:0] dv_dividend, dv_divisor, wb_data;
  logic [RW-1:0]   wb_rd;

  always #5 clk = ~clk;

  div_ctrl #(.XLEN(XLEN), .REG_ADDR_W(RW), .REUSE_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_func3(req_func3), .req_rd(req_rd),
    .flush(flush), .stall(stall), .dv_start(dv_start), .dv_dividend(dv_dividend),
    .dv_divisor(dv_divisor), .dv_abort(dv_abort), .dv_done(dv_done),
    .dv_quotient(dv_quotient), .dv_remainder(dv_remainder), .wb_valid(wb_valid),
    .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd)
  );

  int total = 0, bad = 0;
  int n_starts = 0;
  bit chk_en = 0;

  // model state
  int              m_ph = P_IDLE;
  bit              m_after_rst = 0, m_rv = 0, m_rsgn = 0, m_csgn = 0;
  logic [XLEN-1:0] m_rop1 = '0, m_rop2 = '0, m_cop1 = '0, m_cop2 = '0;
  logic [XLEN-1:0] m_pend = '0, m_wb_data = '0, m_dvd = '0, m_dvs = '0;
  logic [RW-1:0]   m_wb_rd = '0;

  // observations from the last negedge
  bit              obs_ready, obs_stall, obs_start, obs_abort, obs_wbv, obs_rst;
  logic [XLEN-1:0] obs_dvd, obs_dvs, obs_wbd;
  logic [RW-1:0]   obs_wbrd;

  // divider responder
  bit              pend = 0, resp_hold = 0, late_done = 0, spur_en = 0;
  int              cnt = 0;
  logic [XLEN-1:0] ra = '0, rb = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // RISC-V M-extension result from plain arithmetic
  function automatic logic [31:0] ref_res(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f3);
    int sa, sb;
    bit sgn = !f3[0], rem = f3[1];
    if (b == 0) return rem ? a : 32'hFFFFFFFF;
    if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) return rem ? 32'h0 : 32'h80000000;
    if (!sgn) return rem ? a % b : a / b;
    sa = $signed(a);
    sb = $signed(b);
    return rem ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic logic [31:0] mag(input logic [31:0] v, input bit sgn);
    int s = $signed(v);
    return (sgn && s < 0) ? 32'(-s) : v;
  endfunction

  task automatic compare();
    chk("req_ready", req_ready, (m_ph == P_IDLE && !flush));
    chk("stall", stall, ((req_valid && m_ph != P_IDLE) || m_ph == P_START || m_ph == P_WAIT));
    chk("dv_start", dv_start, (m_ph == P_START && !flush));
    chk("dv_abort", dv_abort, (flush && (m_ph == P_START || m_ph == P_WAIT)));
    chk("wb_valid", wb_valid, (m_ph == P_RESP));
    if (m_ph == P_START) begin
      chk("dv_dividend", dv_dividend, m_dvd);
      chk("dv_divisor", dv_divisor, m_dvs);
    end
    if (m_ph == P_RESP) begin
      chk("wb_data", wb_data, m_wb_data);
      chk("wb_rd", 32'(wb_rd), 32'(m_wb_rd));
    end
    if (m_after_rst) begin
      chk("rst_wb_data", wb_data, 0);
      chk("rst_wb_rd", 32'(wb_rd), 0);
      chk("rst_dvd", dv_dividend, 0);
      chk("rst_dvs", dv_divisor, 0);
    end
  endtask

  task automatic model_step();
    bit sgn;
    if (!rst) begin
      m_ph = P_IDLE; m_rv = 0; m_after_rst = 1;
      return;
    end
    m_after_rst = 0;
    if (flush) begin
      m_ph = P_IDLE;
      return;
    end
    case (m_ph)
      P_IDLE: if (req_valid) begin
        sgn = !req_func3[0];
        m_wb_rd = req_rd;
        if (req_op2 == 0 || (sgn && req_op1 == 32'h80000000 && req_op2 == 32'hFFFFFFFF) ||
            (m_rv && m_rop1 == req_op1 && m_rop2 == req_op2 && m_rsgn == sgn)) begin
          m_wb_data = ref_res(req_op1, req_op2, req_func3);
          m_ph = P_RESP;
        end else begin
          m_pend = ref_res(req_op1, req_op2, req_func3);
          m_dvd = mag(req_op1, sgn);
          m_dvs = mag(req_op2, sgn);
          m_cop1 = req_op1; m_cop2 = req_op2; m_csgn = sgn;
          m_ph = P_START;
        end
      end
      P_START: m_ph = P_WAIT;
      P_WAIT: if (dv_done) begin
        m_wb_data = m_pend;
        m_rv = 1; m_rop1 = m_cop1; m_rop2 = m_cop2; m_rsgn = m_csgn;
        m_ph = P_RESP;
      end
      default: if (wb_ready) m_ph = P_IDLE;
    endcase
  endtask

  task automatic responder();
    dv_done = 0;
    dv_quotient = $urandom;
    dv_remainder = $urandom;
    if (!obs_rst || obs_abort) pend = 0;
    else if (obs_start) begin
      pend = 1; cnt = $urandom_range(0, 4); ra = obs_dvd; rb = obs_dvs;
    end else if (pend) begin
      if (!resp_hold) begin
        if (cnt == 0) begin
          dv_done = 1; dv_quotient = ra / rb; dv_remainder = ra % rb; pend = 0;
        end else cnt--;
      end
    end else if (late_done || (spur_en && $urandom_range(0, 11) == 0)) dv_done = 1;
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_en) compare();
    obs_ready = req_ready; obs_stall = stall; obs_start = dv_start; obs_abort = dv_abort;
    obs_wbv = wb_valid; obs_wbd = wb_data; obs_wbrd = wb_rd; obs_rst = rst;
    obs_dvd = dv_dividend; obs_dvs = dv_divisor;
    if (dv_start) n_starts++;
    @(posedge clk);
    model_step();
    #1;
    responder();
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                       input logic [RW-1:0] rd);
    req_op1 = a; req_op2 = b; req_func3 = f3; req_rd = rd; req_valid = 1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (obs_ready) begin
        req_valid = 0;
        return;
      end
    end
    req_valid = 0;
    chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_wb(input string name, input logic [31:0] exp);
    wb_ready = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (obs_wbv) begin
        chk(name, obs_wbd, exp);
        wb_ready = 1;
        tick();
        wb_ready = 0;
        return;
      end
    end
    chk({name, "_timeout"}, 0, 1);
  endtask

  int s0;
  logic [31:0] pool [8];
  logic [31:0] last1 = 0, last2 = 1;

  initial begin
    // pin the model with hand-computed values
    chk("ref_div_m7_2", ref_res(32'hFFFFFFF9, 2, 3'b100), 32'hFFFFFFFD);
    chk("ref_rem_m7_2", ref_res(32'hFFFFFFF9, 2, 3'b110), 32'hFFFFFFFF);
    chk("ref_remu_x0", ref_res(100, 0, 3'b111), 100);
    chk("ref_div_ovf", ref_res(32'h80000000, 32'hFFFFFFFF, 3'b100), 32'h80000000);
    chk("ref_mag", mag(32'hFFFFFFF9, 1), 7);

    tick();
    chk_en = 1;
    tick();
    chk("reset_ready", obs_ready, 1);
    chk("reset_wbv", obs_wbv, 0);
    chk("reset_stall", obs_stall, 0);
    rst = 1;
    tick();

    // DIV -7/2 via divider, then REM -7/2 from the reuse entry
    s0 = n_starts;
    issue(32'hFFFFFFF9, 2, 3'b100, 5'd3);
    tick();
    chk("div_start", obs_start, 1);
    chk("div_dvd", obs_dvd, 7);
    chk("div_dvs", obs_dvs, 2);
    wait_wb("div_m7_2", 32'hFFFFFFFD);
    chk("div_starts", n_starts - s0, 1);
    s0 = n_starts;
    issue(32'hFFFFFFF9, 2, 3'b110, 5'd4);
    tick();
    chk("rem_hit_lat", obs_wbv, 1);
    wait_wb("rem_hit", 32'hFFFFFFFF);
    chk("rem_hit_nostart", n_starts - s0, 0);

    // divide by zero and signed overflow
    s0 = n_starts;
    issue(100, 0, 3'b101, 5'd1);
    wait_wb("divu_x0", 32'hFFFFFFFF);
    issue(100, 0, 3'b111, 5'd2);
    wait_wb("remu_x0", 100);
    issue(32'h80000000, 32'hFFFFFFFF, 3'b100, 5'd6);
    wait_wb("div_ovf", 32'h80000000);
    issue(32'h80000000, 32'hFFFFFFFF, 3'b110, 5'd6);
    wait_wb("rem_ovf", 0);
    chk("special_nostart", n_starts - s0, 0);

    // flush 3 cycles into WAIT, late done, retry misses reuse
    resp_hold = 1;
    issue(1000, 7, 3'b101, 5'd5);
    tick(); tick(); tick(); tick();
    flush = 1;
    tick();
    chk("flush_abort", obs_abort, 1);
    flush = 0;
    tick();
    chk("flush_idle", obs_ready, 1);
    chk("flush_nowbv", obs_wbv, 0);
    resp_hold = 0;
    late_done = 1;
    tick();
    late_done = 0;
    tick();
    chk("late_done_ignored", obs_wbv, 0);
    s0 = n_starts;
    issue(1000, 7, 3'b101, 5'd5);
    wait_wb("retry_divu", 142);
    chk("retry_start", n_starts - s0, 1);

    // wb_ready held low with a new request waiting
    issue(55, 0, 3'b111, 5'd9);
    req_op1 = 3; req_op2 = 4; req_valid = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("hold_wbv", obs_wbv, 1);
      chk("hold_wbd", obs_wbd, 55);
      chk("hold_wbrd", 32'(obs_wbrd), 9);
      chk("hold_stall", obs_stall, 1);
    end
    req_valid = 0;
    wb_ready = 1;
    tick();
    wb_ready = 0;
    tick();
    chk("release_wbv", obs_wbv, 0);

    // reset mid-WAIT clears everything including the reuse entry
    issue(100, 32'hFFFFFFFD, 3'b100, 5'd7);
    wait_wb("div_100_m3", 32'hFFFFFFDF);
    resp_hold = 1;
    issue(200, 3, 3'b101, 5'd8);
    tick(); tick();
    rst = 0;
    tick();
    rst = 1;
    resp_hold = 0;
    tick();
    chk("rst_wbv", obs_wbv, 0);
    chk("rst_ready", obs_ready, 1);
    chk("rst_wbd", obs_wbd, 0);
    chk("rst_dvd_obs", obs_dvd, 0);
    s0 = n_starts;
    issue(100, 32'hFFFFFFFD, 3'b100, 5'd7);
    wait_wb("div_after_rst", 32'hFFFFFFDF);
    chk("rst_reuse_miss", n_starts - s0, 1);

    // random traffic
    spur_en = 1;
    for (int i = 0; i < 3000; i++) begin
      pool[0] = 0; pool[1] = 1; pool[2] = 2; pool[3] = 7;
      pool[4] = 32'hFFFFFFF9; pool[5] = 32'h80000000; pool[6] = 32'hFFFFFFFF; pool[7] = $urandom;
      rst = ($urandom_range(0, 299) != 0);
      flush = ($urandom_range(0, 24) == 0);
      req_valid = ($urandom_range(0, 2) != 0);
      wb_ready = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) begin
        req_op1 = last1; req_op2 = last2;
      end else begin
        req_op1 = pool[$urandom_range(0, 7)];
        req_op2 = ($urandom_range(0, 5) == 0) ? 32'h0 : pool[1 + $urandom_range(0, 6)];
      end
      last1 = req_op1; last2 = req_op2;
      req_func3 = 3'(4 + $urandom_range(0, 3));
      req_rd = RW'($urandom);
      tick();
    end
    rst = 1; flush = 0; req_valid = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
